// File: rtl/otter_mmio_pkg.sv
// Shared MMIO address map, arbiter FSM states and read decode
// for the OTTER memory-mapped IO bus.
`timescale 1ns/1ps
package otter_mmio_pkg;

    localparam logic [31:0] SWITCHES_AD  = 32'h1100_0000;
    localparam logic [31:0] LEDS_AD      = 32'h1100_0020;
    localparam logic [31:0] SSEG_AD      = 32'h1100_0040;
    localparam logic [23:0] MMIO_BASE_HI = 24'h110000;

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        ACK
    } m1_state_e;

    // Read mux shared by the CPU path and master 1
    function automatic logic [31:0] mmio_read(
        input logic [31:0] addr,
        input logic [15:0] sw,
        input logic [15:0] leds,
        input logic [15:0] sseg
    );
        logic [31:0] r;
        r = 32'h0;
        case (addr)
            SWITCHES_AD: r = {16'h0, sw};
            LEDS_AD:     r = {16'h0, leds};
            SSEG_AD:     r = {16'h0, sseg};
            default:     r = 32'h0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mmio_bus_arbiter_sync2.sv
// Two-flop synchronizer for asynchronous board inputs.
// Output follows the input two clock edges later.
`timescale 1ns/1ps
module sync2 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    // Shift the raw input through the two stages
    always_comb begin
        meta_d = d_in;
        sync_d = meta_q;
    end

    // Synchronizer flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign d_out = sync_q;

endmodule

// File: rtl/mmio_bus_arbiter.sv
// OTTER MMIO bus arbiter: CPU has absolute priority, master 1
// waits out CPU bus activity or times out with an error ack.
`timescale 1ns/1ps
module mmio_bus_arbiter
    import otter_mmio_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] IOBUS_ADDR,
    input  logic [31:0] IOBUS_OUT,
    input  logic        IOBUS_WR,
    output logic [31:0] IOBUS_IN,
    input  logic [15:0] SWITCHES,
    output logic [15:0] LEDS,
    output logic [15:0] SSEG,
    input  logic        m1_req,
    input  logic        m1_wr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] m1_rdata
);

    localparam int CW = $clog2(TIMEOUT + 1);

    m1_state_e   state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic        wr_q, wr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0] leds_q, leds_d;
    logic [15:0] sseg_q, sseg_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;

    logic [15:0] sw_sync;
    logic        cpu_busy;
    logic        m1_ok;
    logic        unused_bits;

    sync2 #(.WIDTH(16)) u_sw_sync (
        .clk   (CLK),
        .rst   (RST),
        .d_in  (SWITCHES),
        .d_out (sw_sync)
    );

    // CPU decode, arbitration and master 1 request sequencing
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        leds_d  = leds_q;
        sseg_d  = sseg_q;
        err_d   = err_q;
        rdata_d = rdata_q;

        cpu_busy = (IOBUS_ADDR[31:8] == MMIO_BASE_HI);
        IOBUS_IN = mmio_read(IOBUS_ADDR, sw_sync, leds_q, sseg_q);

        // Read-only SWITCHES and unmapped addresses fail at once
        m1_ok = ((addr_q == SWITCHES_AD) && !wr_q) ||
                (addr_q == LEDS_AD) ||
                (addr_q == SSEG_AD);

        if (IOBUS_WR) begin
            if (IOBUS_ADDR == LEDS_AD) leds_d = IOBUS_OUT[15:0];
            if (IOBUS_ADDR == SSEG_AD) sseg_d = IOBUS_OUT[15:0];
        end

        unique case (state_q)
            IDLE: begin
                if (m1_req) begin
                    addr_d  = m1_addr;
                    wr_d    = m1_wr;
                    wdata_d = m1_wdata[15:0];
                    cnt_d   = '0;
                    state_d = PEND;
                end
            end
            PEND: begin
                if (!m1_ok) begin
                    err_d   = 1'b1;
                    state_d = ACK;
                end else if (!cpu_busy) begin
                    err_d = 1'b0;
                    if (wr_q) begin
                        if (addr_q == LEDS_AD) leds_d = wdata_q;
                        if (addr_q == SSEG_AD) sseg_d = wdata_q;
                    end else begin
                        rdata_d = mmio_read(addr_q, sw_sync,
                                            leds_q, sseg_q);
                    end
                    state_d = ACK;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, request latch and register file
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            cnt_q   <= '0;
            leds_q  <= '0;
            sseg_q  <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            leds_q  <= leds_d;
            sseg_q  <= sseg_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign LEDS     = leds_q;
    assign SSEG     = sseg_q;
    assign m1_ack   = (state_q == ACK);
    assign m1_err   = err_q;
    assign m1_rdata = rdata_q;

    assign unused_bits = ^{IOBUS_OUT[31:16], m1_wdata[31:16]};

endmodule

// File: tb/tb_mmio_bus_arbiter.sv
// Directed bench for mmio_bus_arbiter: CPU path, synchronizer,
// master 1 arbitration, timeout, error acks and mid-request reset.
`timescale 1ns/1ps
module tb_mmio_bus_arbiter;
    import otter_mmio_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] IOBUS_ADDR;
    logic [31:0] IOBUS_OUT;
    logic        IOBUS_WR;
    logic [31:0] IOBUS_IN;
    logic [15:0] SWITCHES;
    logic [15:0] LEDS;
    logic [15:0] SSEG;
    logic        m1_req;
    logic        m1_wr;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic        m1_ack;
    logic        m1_err;
    logic [31:0] m1_rdata;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc;

    mmio_bus_arbiter #(.TIMEOUT(16)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .IOBUS_ADDR (IOBUS_ADDR),
        .IOBUS_OUT  (IOBUS_OUT),
        .IOBUS_WR   (IOBUS_WR),
        .IOBUS_IN   (IOBUS_IN),
        .SWITCHES   (SWITCHES),
        .LEDS       (LEDS),
        .SSEG       (SSEG),
        .m1_req     (m1_req),
        .m1_wr      (m1_wr),
        .m1_addr    (m1_addr),
        .m1_wdata   (m1_wdata),
        .m1_ack     (m1_ack),
        .m1_err     (m1_err),
        .m1_rdata   (m1_rdata)
    );

    always #10 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Cycle 0 is the cycle in which m1_req first goes high.
    // The CPU bus stays busy through cycle busy_last.
    task automatic m1_txn(input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, input int busy_last,
                          output int ack_cyc);
        m1_req   = 1'b1;
        m1_wr    = wr;
        m1_addr  = addr;
        m1_wdata = wd;
        ack_cyc  = 99;
        for (int c = 1; c <= 40; c++) begin
            step();
            IOBUS_WR = 1'b0;
            if (c > busy_last) IOBUS_ADDR = 32'h0000_1000;
            if (m1_ack) begin
                ack_cyc = c;
                break;
            end
        end
        m1_req = 1'b0;
        step();
        check("ack_one_cycle", {31'h0, m1_ack}, 32'h0);
    endtask

    initial begin
        RST        = 1'b1;
        IOBUS_ADDR = LEDS_AD;
        IOBUS_OUT  = 32'h0;
        IOBUS_WR   = 1'b0;
        SWITCHES   = 16'h0;
        m1_req     = 1'b0;
        m1_wr      = 1'b0;
        m1_addr    = 32'h0;
        m1_wdata   = 32'h0;

        step();
        step();
        check("rst_leds", {16'h0, LEDS}, 32'h0);
        check("rst_sseg", {16'h0, SSEG}, 32'h0);
        check("rst_ack", {31'h0, m1_ack}, 32'h0);
        check("rst_err", {31'h0, m1_err}, 32'h0);
        check("rst_rdata", m1_rdata, 32'h0);
        check("rst_iobus_in", IOBUS_IN, 32'h0);
        RST = 1'b0;

        IOBUS_ADDR = LEDS_AD;
        IOBUS_OUT  = 32'hFFFF_A5A5;
        IOBUS_WR   = 1'b1;
        step();
        IOBUS_WR = 1'b0;
        check("cpu_wr_leds", {16'h0, LEDS}, 32'h0000_A5A5);
        check("cpu_rd_leds", IOBUS_IN, 32'h0000_A5A5);

        SWITCHES   = 16'h1234;
        IOBUS_ADDR = SWITCHES_AD;
        step();
        check("sw_one_edge", IOBUS_IN, 32'h0);
        step();
        check("sw_two_edges", IOBUS_IN, 32'h0000_1234);

        IOBUS_ADDR = 32'h0000_1000;
        m1_txn(1'b1, SSEG_AD, 32'h0000_BEEF, -1, cyc);
        check("m1_wr_cyc", cyc, 2);
        check("m1_wr_err", {31'h0, m1_err}, 32'h0);
        check("m1_wr_sseg", {16'h0, SSEG}, 32'h0000_BEEF);

        m1_txn(1'b0, SSEG_AD, 32'h0, -1, cyc);
        check("m1_rd_cyc", cyc, 2);
        check("m1_rd_data", m1_rdata, 32'h0000_BEEF);

        IOBUS_ADDR = LEDS_AD;
        IOBUS_OUT  = 32'h0000_5A5A;
        IOBUS_WR   = 1'b1;
        m1_txn(1'b0, LEDS_AD, 32'h0, 5, cyc);
        check("busy5_cyc", cyc, 7);
        check("busy5_err", {31'h0, m1_err}, 32'h0);
        check("busy5_rdata", m1_rdata, 32'h0000_5A5A);
        check("busy5_leds", {16'h0, LEDS}, 32'h0000_5A5A);

        IOBUS_ADDR = SWITCHES_AD;
        m1_txn(1'b1, LEDS_AD, 32'h0000_1111, 20, cyc);
        IOBUS_ADDR = 32'h0000_1000;
        check("tmo_cyc", cyc, 17);
        check("tmo_err", {31'h0, m1_err}, 32'h1);
        check("tmo_leds", {16'h0, LEDS}, 32'h0000_5A5A);
        check("tmo_sseg", {16'h0, SSEG}, 32'h0000_BEEF);

        m1_txn(1'b0, 32'h1100_0080, 32'h0, -1, cyc);
        check("unmap_cyc", cyc, 2);
        check("unmap_err", {31'h0, m1_err}, 32'h1);

        m1_txn(1'b1, SWITCHES_AD, 32'h0000_FFFF, -1, cyc);
        check("swwr_cyc", cyc, 2);
        check("swwr_err", {31'h0, m1_err}, 32'h1);
        IOBUS_ADDR = SWITCHES_AD;
        #1;
        check("swwr_noeffect", IOBUS_IN, 32'h0000_1234);

        m1_txn(1'b0, LEDS_AD, 32'h0, -1, cyc);
        check("ok_after_err", {31'h0, m1_err}, 32'h0);

        IOBUS_ADDR = SWITCHES_AD;
        m1_req     = 1'b1;
        m1_wr      = 1'b1;
        m1_addr    = LEDS_AD;
        m1_wdata   = 32'h0000_7777;
        step();
        step();
        check("pend_no_ack", {31'h0, m1_ack}, 32'h0);
        RST    = 1'b1;
        m1_req = 1'b0;
        #1;
        check("rstp_leds", {16'h0, LEDS}, 32'h0);
        check("rstp_sseg", {16'h0, SSEG}, 32'h0);
        check("rstp_ack", {31'h0, m1_ack}, 32'h0);
        check("rstp_state", {30'h0, dut.state_q}, {30'h0, IDLE});
        check("rstp_sw", IOBUS_IN, 32'h0);
        step();
        RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rstp_post_ack", {31'h0, m1_ack}, 32'h0);
        end
        check("rstp_post_leds", {16'h0, LEDS}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/mmio_bus_arbiter.md
# mmio_bus_arbiter

Shares the OTTER memory-mapped IO bus between the CPU (master 0, cannot stall) and a secondary debug/loader master (master 1, req/ack handshake). It owns the board output registers (LEDS, SSEG) and the synchronized SWITCHES input, and decodes all MMIO addresses. It sits in the top-level wrapper between OtterTopModule's IOBUS and the board peripherals, replacing the ad-hoc decode logic there.

## Interface
- TIMEOUT, 16: max cycles master 1 waits in PEND before an error ack.
- CLK  in  1  system clock (50 MHz CPU clock).
- RST  in  1  reset; one clock, asynchronous, active-high.
- IOBUS_ADDR  in  32  CPU MMIO address.
- IOBUS_OUT  in  32  CPU write data.
- IOBUS_WR  in  1  CPU write strobe.
- IOBUS_IN  out  32  CPU read data (combinational).
- SWITCHES  in  16  raw board switches (asynchronous).
- LEDS  out  16  LED register.
- SSEG  out  16  seven-segment data register.
- m1_req  in  1  master 1 request; addr/wr/wdata stable while high.
- m1_wr  in  1  1 = write, 0 = read.
- m1_addr  in  32  master 1 address.
- m1_wdata  in  32  master 1 write data.
- m1_ack  out  1  one-cycle completion pulse.
- m1_err  out  1  valid with m1_ack: timeout or unmapped address.
- m1_rdata  out  32  read data, valid with m1_ack.

## Operation
- Map: 0x1100_0000 SWITCHES (RO, {16'b0, sw_sync}); 0x1100_0020 LEDS (RW, [15:0]); 0x1100_0040 SSEG (RW, [15:0]). Upper 16 bits read 0, ignored on write. Any other address reads 0.
- cpu_busy = (IOBUS_ADDR[31:8] == 24'h110000). Conservative: counted busy even without IOBUS_WR.
- CPU path: IOBUS_IN decoded combinationally from IOBUS_ADDR; writes commit on the CLK edge where IOBUS_WR=1. Always wins; never delayed.
- Master 1 FSM: IDLE, PEND, ACK.
  - IDLE: m1_req=1 → latch addr/wr/wdata, clear wait counter, → PEND.
  - PEND: unmapped latched addr → ACK with err=1, no access. Else !cpu_busy → perform access (write commits / rdata captured on this edge) → ACK. Else counter+1; counter == TIMEOUT-1 → ACK with err=1, no access.
  - ACK: m1_ack=1 one cycle → IDLE unconditionally. Master drops m1_req in the ack cycle; req still high in IDLE is a new request.
- Writes to SWITCHES address: err=0, no effect (CPU) / err=1 (master 1).
- Simultaneous CPU write and master 1 access to same register: CPU always goes first (master 1 waits while cpu_busy), so no merge case exists.
- SWITCHES passed through 2-flop synchronizer; reads see sw_sync.

## Timing
- Reset: LEDS=0, SSEG=0, sw_sync=0, m1_ack=0, m1_err=0, m1_rdata=0, state IDLE, counter 0. IOBUS_IN follows address (0 unless SWITCHES, LEDS or SSEG is addressed).
- Master 1 best-case latency: req high cycle 0, access on edge ending cycle 1, m1_ack high cycle 2.
- Worst case: ack in cycle TIMEOUT+1 with err=1.
- Switch change visible to reads 2 edges later.
- RST mid-transaction: pending access dropped, no ack, registers to reset values.
- m1_rdata/m1_err hold their last value outside ACK.

## Structure
- Package otter_mmio_pkg: SWITCHES_AD, LEDS_AD, SSEG_AD, MMIO_BASE_HI (24'h110000), state enum {IDLE, PEND, ACK}.
- Sub-module sync2 (parameterized-width 2-flop synchronizer) for SWITCHES.
- FSM, wait counter, register file and decode in mmio_bus_arbiter.

## Test plan
- Reset, then CPU write 0x0000_A5A5 to 0x1100_0020 → LEDS=0xA5A5 next edge; IOBUS_IN at that address = 0x0000_A5A5.
- SWITCHES=0x1234, IOBUS_ADDR=0x1100_0000, wait 2 edges → IOBUS_IN=0x0000_1234.
- CPU address 0x0000_1000, master 1 writes 0xBEEF to 0x1100_0040 → m1_ack in cycle 2, err=0, SSEG=0xBEEF.
- cpu_busy held 5 cycles, master 1 reads LEDS → ack 5 cycles later than best case with current LEDS value; same-cycle CPU LEDS write lands first.
- cpu_busy held 20 cycles with TIMEOUT=16 → ack in cycle 17 with err=1, registers unchanged; master 1 access to 0x1100_0080 → ack cycle 2, err=1.
- RST asserted while in PEND → no ack, LEDS=SSEG=0, FSM in IDLE.
